// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for the RISC-V datapath: fetch handshake, IR latch,
// phase sequencing (IF/ID/EX/MEM/WB), control decode, fault and retire tracking.
module controle_multiciclo #(
  parameter int unsigned RET_W    = 32,
  parameter int unsigned FETCH_TO = 15
) (
  input  logic             clk,
  input  logic             reset,
  output logic             instr_req,
  input  logic             instr_valid,
  input  logic [31:0]      instr_in,
  input  logic             mem_ready,
  input  logic             zero,
  output logic [2:0]       estado,
  output logic             pcsrc,
  output logic [11:0]      immediate,
  output logic             regwrite,
  output logic             memread,
  output logic             memwrite,
  output logic             alusrc,
  output logic             memtoreg,
  output logic [1:0]       aluop,
  output logic             fault,
  output logic [RET_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EX  = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100
  } state_t;

  localparam logic [6:0]  OP_R   = 7'b0110011;
  localparam logic [6:0]  OP_I   = 7'b0010011;
  localparam logic [6:0]  OP_LW  = 7'b0000011;
  localparam logic [6:0]  OP_SW  = 7'b0100011;
  localparam logic [6:0]  OP_BEQ = 7'b1100011;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  localparam int unsigned      TO_W    = (FETCH_TO > 1) ? $clog2(FETCH_TO) : 1;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'((FETCH_TO == 0) ? 0 : FETCH_TO - 1);

  state_t            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              fault_q, fault_d;
  logic              pcsrc_q, pcsrc_d;
  logic [RET_W-1:0]  retired_q, retired_d;

  logic [6:0] opcode;
  logic       is_r, is_i, is_lw, is_sw, is_beq, is_legal, exec_phase;
  logic       ir_unused;

  assign opcode   = ir_q[6:0];
  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_legal = is_r | is_i | is_lw | is_sw | is_beq;

  // rs1/rs2/rd/funct3 belong to the datapath, not to this controller
  assign ir_unused = ^ir_q[24:12];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IF;
      ir_q      <= '0;
      to_cnt_q  <= '0;
      fault_q   <= 1'b0;
      pcsrc_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      to_cnt_q  <= to_cnt_d;
      fault_q   <= fault_d;
      pcsrc_q   <= pcsrc_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    to_cnt_d  = to_cnt_q;
    fault_d   = fault_q;
    pcsrc_d   = pcsrc_q;
    retired_d = retired_q;
    regwrite  = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    memtoreg  = 1'b0;

    case (state_q)
      S_IF: begin
        if (instr_valid) begin
          ir_d     = instr_in;
          to_cnt_d = '0;
          state_d  = S_ID;
        end else if ((FETCH_TO != 0) && (to_cnt_q == TO_LAST)) begin
          // Timed-out fetch still retires, as a harmless NOP
          fault_d  = 1'b1;
          ir_d     = NOP;
          to_cnt_d = '0;
          state_d  = S_ID;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_ID: begin
        if (is_legal) begin
          state_d = S_EX;
        end else begin
          fault_d = 1'b1;
          state_d = S_WB;
        end
      end
      S_EX: begin
        if (is_beq) begin
          pcsrc_d = zero;
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        memread  = is_lw;
        memwrite = is_sw;
        if (mem_ready) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        regwrite  = is_r | is_i | is_lw;
        memtoreg  = is_lw;
        retired_d = retired_q + 1'b1;
        pcsrc_d   = 1'b0;
        state_d   = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  assign exec_phase = (state_q == S_EX) || (state_q == S_MEM) || (state_q == S_WB);

  always_comb begin
    alusrc = 1'b0;
    aluop  = 2'b00;
    if (exec_phase) begin
      alusrc = is_i | is_lw | is_sw;
      if (is_r || is_i) begin
        aluop = 2'b10;
      end else if (is_beq) begin
        aluop = 2'b01;
      end
    end
  end

  assign estado    = state_q;
  assign instr_req = (state_q == S_IF);
  assign immediate = {ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8]};
  assign pcsrc     = pcsrc_q;
  assign fault     = fault_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench for controle_multiciclo: directed scenarios plus random
// instruction streams compared cycle by cycle against a phase-list model.
module tb_controle_multiciclo;

  localparam int unsigned RET_W    = 32;
  localparam int unsigned FETCH_TO = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic             instr_req;
  logic             instr_valid;
  logic [31:0]      instr_in;
  logic             mem_ready;
  logic             zero;
  logic [2:0]       estado;
  logic             pcsrc;
  logic [11:0]      immediate;
  logic             regwrite, memread, memwrite, alusrc, memtoreg;
  logic [1:0]       aluop;
  logic             fault;
  logic [RET_W-1:0] retired;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [RET_W-1:0] m_retired;
  logic             m_fault;

  always #5 clk = ~clk;

  controle_multiciclo #(.RET_W(RET_W), .FETCH_TO(FETCH_TO)) dut (
    .clk(clk), .reset(reset), .instr_req(instr_req), .instr_valid(instr_valid),
    .instr_in(instr_in), .mem_ready(mem_ready), .zero(zero), .estado(estado),
    .pcsrc(pcsrc), .immediate(immediate), .regwrite(regwrite), .memread(memread),
    .memwrite(memwrite), .alusrc(alusrc), .memtoreg(memtoreg), .aluop(aluop),
    .fault(fault), .retired(retired)
  );

  // 0 R, 1 I, 2 LW, 3 SW, 4 BEQ, 5 illegal
  function automatic int unsigned kind_of(input logic [31:0] w);
    case (w[6:0])
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return 4;
      default:    return 5;
    endcase
  endfunction

  // Runs one instruction from an IF-cycle negedge to the next IF-cycle negedge.
  task automatic run_instr(input logic [31:0] instr, input int unsigned fw,
                           input logic z, input int unsigned mw, input string tag);
    int unsigned ph[$];
    int unsigned k, n_if, ifk, memk;
    bit          to;
    logic [31:0] eff;
    logic [11:0] e_imm;
    logic [12:0] exp_v, act_v;
    bit          e_rw, e_mr, e_mw, e_mtr, e_as, e_pc, ex;
    logic [1:0]  e_aop;

    to   = (fw >= FETCH_TO);
    eff  = to ? 32'h0000_0013 : instr;
    n_if = to ? FETCH_TO : fw + 1;
    k    = kind_of(eff);
    for (int unsigned i = 0; i < n_if; i++) ph.push_back(0);
    ph.push_back(1);
    if (k == 5) begin
      ph.push_back(4);
    end else begin
      ph.push_back(2);
      if (k == 2 || k == 3) for (int unsigned i = 0; i <= mw; i++) ph.push_back(3);
      ph.push_back(4);
    end
    e_imm = {eff[31], eff[7], eff[30:25], eff[11:8]};

    ifk = 0; memk = 0;
    for (int unsigned i = 0; i < ph.size(); i++) begin
      int unsigned p;
      p     = ph[i];
      ex    = (p >= 2) && (k != 5);
      e_rw  = (p == 4) && (k <= 2);
      e_mr  = (p == 3) && (k == 2);
      e_mw  = (p == 3) && (k == 3);
      e_mtr = (p == 4) && (k == 2);
      e_as  = ex && (k == 1 || k == 2 || k == 3);
      e_aop = !ex ? 2'd0 : (k <= 1) ? 2'd2 : (k == 4) ? 2'd1 : 2'd0;
      e_pc  = (p == 4) && (k == 4) && z;
      exp_v = {3'(p), (p == 0), e_rw, e_mr, e_mw, e_mtr, e_as, e_aop, e_pc, m_fault};
      act_v = {estado, instr_req, regwrite, memread, memwrite, memtoreg, alusrc, aluop, pcsrc, fault};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL %s ctrl cycle %0d: got %b want %b (estado,req,rw,mr,mw,mtr,as,aop,pc,fault)",
                 tag, i, act_v, exp_v);
      end
      total++;
      if (retired !== m_retired) begin
        bad++;
        $display("FAIL %s retired cycle %0d: got %0d want %0d", tag, i, retired, m_retired);
      end
      if (p != 0) begin
        total++;
        if (immediate !== e_imm) begin
          bad++;
          $display("FAIL %s immediate cycle %0d: got %h want %h", tag, i, immediate, e_imm);
        end
      end

      if (p == 0) begin
        instr_valid = !to && (ifk == fw);
        instr_in    = instr_valid ? instr : 32'($urandom());
        ifk++;
      end else begin
        instr_valid = 1'($urandom());
        instr_in    = 32'($urandom());
      end
      if (p == 3) begin
        mem_ready = (memk == mw);
        memk++;
      end else begin
        mem_ready = 1'($urandom());
      end
      zero = (p == 2) ? z : 1'($urandom());
      @(negedge clk);

      if (p == 0 && to && ifk == n_if) m_fault = 1'b1;
      if (p == 1 && k == 5)            m_fault = 1'b1;
      if (p == 4)                      m_retired = m_retired + 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; instr_valid = 1'b0; instr_in = '0; mem_ready = 1'b0; zero = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({estado, instr_req, pcsrc, regwrite, memread, memwrite, alusrc, memtoreg, aluop, fault} !== 13'b000_1_0_00000_00_0) begin
      bad++;
      $display("FAIL reset_ctrl: got estado=%b req=%b pc=%b rw=%b mr=%b mw=%b as=%b mtr=%b aop=%b f=%b want 000 1 all-zero",
               estado, instr_req, pcsrc, regwrite, memread, memwrite, alusrc, memtoreg, aluop, fault);
    end
    total++;
    if (retired !== '0) begin
      bad++;
      $display("FAIL reset_retired: got %0d want 0", retired);
    end
    reset = 1'b1;
    m_retired = '0;
    m_fault   = 1'b0;
  endtask

  task automatic test_add();
    run_instr(32'h00B5_0533, 0, 1'b0, 0, "add");
    total++;
    if (retired !== 1) begin
      bad++;
      $display("FAIL add_retired: got %0d want 1", retired);
    end
  endtask

  task automatic test_beq();
    run_instr(32'h00B5_0463, 0, 1'b1, 0, "beq_taken");
    run_instr(32'h00B5_0463, 1, 1'b0, 0, "beq_not_taken");
    total++;
    if (immediate !== 12'h004) begin
      bad++;
      $display("FAIL beq_immediate: got %h want 004", immediate);
    end
  endtask

  task automatic test_lw_wait();
    run_instr(32'h0005_A503, 0, 1'b0, 3, "lw_wait3");
    run_instr(32'h00B5_2023, 2, 1'b0, 0, "sw_ready");
  endtask

  task automatic test_illegal();
    run_instr(32'h0000_007F, 0, 1'b0, 0, "illegal");
    total++;
    if (fault !== 1'b1) begin
      bad++;
      $display("FAIL illegal_fault: got %b want 1", fault);
    end
  endtask

  task automatic test_timeout_and_reset();
    reset = 1'b0; @(negedge clk); reset = 1'b1;
    m_retired = '0; m_fault = 1'b0;
    run_instr(32'h00B5_0533, FETCH_TO - 1, 1'b0, 0, "fetch_last_cycle");
    run_instr(32'($urandom()), FETCH_TO, 1'b0, 0, "timeout_nop");
    total++;
    if (fault !== 1'b1 || retired !== 2) begin
      bad++;
      $display("FAIL timeout_fault: got fault=%b retired=%0d want fault=1 retired=2", fault, retired);
    end
    instr_valid = 1'b1; instr_in = 32'h00B5_2023; mem_ready = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (estado !== 3'b011 || memwrite !== 1'b1) begin
      bad++;
      $display("FAIL sw_in_mem: got estado=%b memwrite=%b want 011 1", estado, memwrite);
    end
    reset = 1'b0;
    #1;
    total++;
    if (memwrite !== 1'b0 || estado !== 3'b000 || fault !== 1'b0 || retired !== '0 || pcsrc !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got mw=%b estado=%b fault=%b retired=%0d pcsrc=%b want 0 000 0 0 0",
               memwrite, estado, fault, retired, pcsrc);
    end
    @(negedge clk);
    reset = 1'b1;
    m_retired = '0; m_fault = 1'b0;
    run_instr(32'h00B5_0533, 0, 1'b0, 0, "after_reset");
  endtask

  task automatic test_retired_wrap();
    instr_valid = 1'b0;
    force dut.retired_q = '1;
    @(posedge clk);
    #1;
    release dut.retired_q;
    @(negedge clk);
    m_retired = '1;
    run_instr(32'h0010_0093, 0, 1'b0, 0, "wrap");
    total++;
    if (retired !== '0) begin
      bad++;
      $display("FAIL retired_wrap: got %0d want 0", retired);
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [6:0]  op;
    int unsigned sel, fw;
    for (int unsigned n = 0; n < 60; n++) begin
      w   = $urandom();
      sel = $urandom_range(0, 5);
      case (sel)
        0: op = 7'b0110011;
        1: op = 7'b0010011;
        2: op = 7'b0000011;
        3: op = 7'b0100011;
        4: op = 7'b1100011;
        default: begin
          op = 7'($urandom());
          while (kind_of({25'd0, op}) != 5) op = op + 7'd1;
        end
      endcase
      w[6:0] = op;
      fw = ($urandom_range(0, 9) == 0) ? $urandom_range(FETCH_TO - 1, FETCH_TO + 2) : $urandom_range(0, 3);
      run_instr(w, fw, 1'($urandom()), $urandom_range(0, 4), "random");
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_beq();
    test_lw_wait();
    test_illegal();
    test_timeout_and_reset();
    test_retired_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, bench did not complete");
    $fatal(1, "watchdog");
  end

endmodule
